grid_cursor_ctrl: RTL and testbench

Button front-end for the 3x3 VGA grid display, clocked by the 25 MHz pixel clock. Synchronises and debounces the four raw board pushbuttons and converts each accepted press into a one-step move of a cursor on the 3x3 grid, with wrap-around. Feeds the cell-colouring stage: that stage reads cur_row/cur_col/cell_idx when it paints the selected cell, and reads move_pulse as an update strobe.

---
 rtl/grid_cursor_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_grid_cursor_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/grid_cursor_ctrl.sv
// Pushbutton front-end for the 3x3 grid: sync, debounce, press detect, wrapping cursor moves.
// Define GRID_CURSOR_AUTOREPEAT_EN to build the hold-to-repeat counter.
module grid_cursor_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 12500000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Btn_UP,
   input  logic       Btn_Down,
   input  logic       Btn_Left,
   input  logic       Btn_Right,
   output logic [1:0] cur_row,
   output logic [1:0] cur_col,
   output logic [3:0] cell_idx,
   output logic       move_pulse,
   output logic [1:0] move_dir,
   output logic [3:0] btn_state
);

   localparam int unsigned NBTN  = 4;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
      $error("grid_cursor_ctrl: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
   end

   // Button vectors are ordered {up, down, left, right}
   logic [NBTN-1:0] raw_c, norm_c;
   logic [NBTN-1:0] sync1_q, sync2_q;
   logic [NBTN-1:0] deb_q, deb_d, deb_prev_q;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];
   logic [NBTN-1:0] press_q;
   logic [NBTN-1:0] rpt_c;
   logic [NBTN-1:0] event_c;

   logic [1:0] row_q, row_d, col_q, col_d, dir_q, dir_d;
   logic [3:0] idx_q, idx_d;
   logic       pulse_q, pulse_d;

   assign raw_c  = {Btn_UP, Btn_Down, Btn_Left, Btn_Right};
   assign norm_c = BTN_ACTIVE_LOW ? ~raw_c : raw_c;

   // Per-button debounce: level flips after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      deb_d = deb_q;
      for (int b = 0; b < NBTN; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[b] = ~deb_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

`ifdef GRID_CURSOR_AUTOREPEAT_EN
   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_lim_c;
   logic              hold_act_q, hold_act_d, hold_first_q, hold_first_d;
   logic [NBTN-1:0]   hold_btn_q, hold_btn_d;
   logic              single_c;

   assign single_c   = (deb_q != '0) && ((deb_q & (deb_q - NBTN'(1))) == '0);
   assign hold_lim_c = hold_first_q ? HOLD_W'(REPEAT_DELAY - 1) : HOLD_W'(REPEAT_PERIOD - 1);

   // Hold counter runs only while the same single button stays the only one pressed
   always_comb begin
      hold_cnt_d   = hold_cnt_q;
      hold_act_d   = hold_act_q;
      hold_first_d = hold_first_q;
      hold_btn_d   = hold_btn_q;
      rpt_c        = '0;
      if (press_q != '0 && single_c && press_q == deb_q) begin
         hold_act_d   = 1'b1;
         hold_first_d = 1'b1;
         hold_cnt_d   = '0;
         hold_btn_d   = deb_q;
      end else if (hold_act_q && deb_q == hold_btn_q) begin
         if (hold_cnt_q == hold_lim_c) begin
            rpt_c        = hold_btn_q;
            hold_cnt_d   = '0;
            hold_first_d = 1'b0;
         end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end else begin
         hold_act_d = 1'b0;
         hold_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt_q   <= '0;
         hold_act_q   <= 1'b0;
         hold_first_q <= 1'b0;
         hold_btn_q   <= '0;
      end else begin
         hold_cnt_q   <= hold_cnt_d;
         hold_act_q   <= hold_act_d;
         hold_first_q <= hold_first_d;
         hold_btn_q   <= hold_btn_d;
      end
   end
`else
   assign rpt_c = '0;
`endif

   assign event_c = press_q | rpt_c;

   // Single winning move per cycle, priority up > down > left > right
   always_comb begin
      row_d   = row_q;
      col_d   = col_q;
      dir_d   = dir_q;
      pulse_d = 1'b0;
      if (event_c[3]) begin
         row_d   = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
         dir_d   = 2'd0;
         pulse_d = 1'b1;
      end else if (event_c[2]) begin
         row_d   = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
         dir_d   = 2'd1;
         pulse_d = 1'b1;
      end else if (event_c[1]) begin
         col_d   = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
         dir_d   = 2'd2;
         pulse_d = 1'b1;
      end else if (event_c[0]) begin
         col_d   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
         dir_d   = 2'd3;
         pulse_d = 1'b1;
      end
      idx_d = 4'(row_d) * 4'd3 + 4'(col_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         press_q    <= '0;
         for (int b = 0; b < NBTN; b++) cnt_q[b] <= '0;
         row_q      <= 2'd1;
         col_q      <= 2'd1;
         idx_q      <= 4'd4;
         dir_q      <= 2'd0;
         pulse_q    <= 1'b0;
      end else begin
         sync1_q    <= norm_c;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         press_q    <= deb_q & ~deb_prev_q;
         for (int b = 0; b < NBTN; b++) cnt_q[b] <= cnt_d[b];
         row_q      <= row_d;
         col_q      <= col_d;
         idx_q      <= idx_d;
         dir_q      <= dir_d;
         pulse_q    <= pulse_d;
      end
   end

   assign cur_row    = row_q;
   assign cur_col    = col_q;
   assign cell_idx   = idx_q;
   assign move_pulse = pulse_q;
   assign move_dir   = dir_q;
   assign btn_state  = deb_q;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Scoreboard bench for grid_cursor_ctrl: directed plan scenarios plus random button activity.
module tb_grid_cursor_ctrl;
   localparam int unsigned DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       up, dn, lf, rt;
   logic [1:0] cur_row, cur_col, move_dir;
   logic [3:0] cell_idx, btn_state;
   logic       move_pulse;

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned cyc = 0;

   grid_cursor_ctrl #(.DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .Btn_UP(up), .Btn_Down(dn), .Btn_Left(lf), .Btn_Right(rt),
      .cur_row(cur_row), .cur_col(cur_col), .cell_idx(cell_idx),
      .move_pulse(move_pulse), .move_dir(move_dir), .btn_state(btn_state)
   );

   always #5 clk = ~clk;

   typedef struct {int unsigned due; int row; int col; int dir;} exp_t;
   exp_t sbq[$];

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
      end
   endtask

   // Reference model: a button is accepted once its synchronised level has disagreed with the
   // accepted level for the last DEB samples; the cursor moves two cycles after acceptance.
   bit [3:0] m_s1, m_s2, m_deb, m_rose, m_press, p, nd;
   bit [3:0] m_win [DEB];
   int m_row = 1, m_col = 1, m_dir = 0;

   always @(posedge clk) begin
      cyc++;
      p = ~{up, dn, lf, rt};
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_deb = '0; m_rose = '0; m_press = '0;
         for (int i = 0; i < DEB; i++) m_win[i] = '0;
         m_row = 1; m_col = 1; m_dir = 0;
      end else begin
         if (m_press != '0) begin
            if (m_press[3])      begin m_row = (m_row + 2) % 3; m_dir = 0; end
            else if (m_press[2]) begin m_row = (m_row + 1) % 3; m_dir = 1; end
            else if (m_press[1]) begin m_col = (m_col + 2) % 3; m_dir = 2; end
            else                 begin m_col = (m_col + 1) % 3; m_dir = 3; end
            sbq.push_back('{cyc, m_row, m_col, m_dir});
         end
         m_press = m_rose;
         for (int i = DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
         m_win[0] = m_s2;
         nd = m_deb;
         for (int b = 0; b < 4; b++) begin
            bit stable;
            stable = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_win[i][b] == m_deb[b]) stable = 1'b0;
            if (stable) nd[b] = ~m_deb[b];
         end
         m_rose = nd & ~m_deb;
         m_deb  = nd;
         m_s2   = m_s1;
         m_s1   = p;
      end
   end

   // Monitor: pops an expected move whenever the DUT strobes, and checks state every cycle
   always @(negedge clk) begin
      exp_t e;
      chk("btn_state", int'(btn_state), int'(m_deb));
      chk("cur_row", int'(cur_row), m_row);
      chk("cur_col", int'(cur_col), m_col);
      chk("cell_idx", int'(cell_idx), m_row * 3 + m_col);
      if (move_pulse) begin
         if (sbq.size() == 0) begin
            chk("unexpected_move_pulse", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("move_cycle", int'(cyc), int'(e.due));
            chk("move_row", int'(cur_row), e.row);
            chk("move_col", int'(cur_col), e.col);
            chk("move_dir", int'(move_dir), e.dir);
         end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         chk("missing_move_pulse", 0, 1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      step(n);
      rst_n = 1'b1;
   endtask

   task automatic set_btn(input bit [3:0] pressed);
      {up, dn, lf, rt} = ~pressed;
   endtask

   initial begin
      int unsigned start;
      bit seen;
      {up, dn, lf, rt} = 4'hF;
      do_reset(2);
      chk("reset_row", int'(cur_row), 1);
      chk("reset_col", int'(cur_col), 1);
      chk("reset_idx", int'(cell_idx), 4);
      chk("reset_pulse", int'(move_pulse), 0);
      chk("reset_btn", int'(btn_state), 0);
      step(3);

      // clean press with explicit latency check
      set_btn(4'b0001);
      start = cyc;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (move_pulse) begin
            seen = 1'b1;
            chk("latency", int'(cyc - start), 8);
            chk("press_col", int'(cur_col), 2);
            chk("press_idx", int'(cell_idx), 5);
            chk("press_dir", int'(move_dir), 3);
         end
      end
      chk("press_seen", int'(seen), 1);
      step(4);
      set_btn(4'b0000);
      step(12);

      // wrap-around
      do_reset(2);
      for (int k = 0; k < 2; k++) begin set_btn(4'b0001); step(10); set_btn(4'b0000); step(10); end
      for (int k = 0; k < 2; k++) begin set_btn(4'b1000); step(10); set_btn(4'b0000); step(10); end

      // bounce then a real hold
      do_reset(2);
      set_btn(4'b0100); step(3); set_btn(4'b0000); step(1);
      set_btn(4'b0100); step(2); set_btn(4'b0000); step(8);
      set_btn(4'b0100); step(10); set_btn(4'b0000); step(10);

      // simultaneous up+left
      do_reset(2);
      set_btn(4'b1010); step(12); set_btn(4'b0000); step(10);

      // reset mid-debounce while held
      do_reset(2);
      set_btn(4'b0010); step(3);
      do_reset(1);
      step(15); set_btn(4'b0000); step(10);

      // random activity with glitches and occasional resets
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 29) == 0) begin
            do_reset($urandom_range(1, 2));
         end else begin
            bit [3:0] m;
            m = '0;
            for (int b = 0; b < 4; b++) m[b] = ($urandom_range(0, 3) == 0);
            set_btn(m);
            step($urandom_range(1, 10));
         end
      end
      set_btn(4'b0000);
      step(15);
      chk("queue_drained", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
